mult_arbiter: RTL and testbench
===============================

Name: mult_arbiter

Overview:
Shares one registered signed 16x16 multiplier between N_REQ particle update engines, so each particle no longer needs its own multiplier. Requesters present operands with a level request. A round-robin arbiter grants one requester per cycle, and the product is returned one cycle later, tagged to that requester. The block sits between the particle array and a single DSP multiplier in the simulation top level.

Parameters:
N_REQ, 4, number of requesters (2..16)
WIDTH, 16, operand/result width in bits (signed, matches shortint fixed-point)
FRAC, 4, fractional bits; the full product is shifted right arithmetically by FRAC before narrowing
SATURATE, 0, 1 = clamp the narrowed result to the signed WIDTH range; 0 = truncate to the low WIDTH bits

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-low reset (0 = reset)
req  in  N_REQ  level request, one bit per requester
a  in  N_REQ*WIDTH  operand A per requester, packed, requester i at [i*WIDTH +: WIDTH], signed
b  in  N_REQ*WIDTH  operand B per requester, same packing, signed
grant  out  N_REQ  one-hot, combinational; operands of the granted requester are captured at this clock edge
rsp_valid  out  N_REQ  one-hot, registered; the result for that requester is present this cycle
rsp_data  out  WIDTH  registered result (signed)
rsp_id  out  $clog2(N_REQ)  index of the requester owning rsp_data
busy  out  1  registered; high when any grant occurred in the previous cycle

Behaviour:
- Reset (reset==0 at a clk edge):
  - rsp_valid=0, rsp_data=0, rsp_id=0, busy=0.
  - Round-robin pointer ptr=0; captured operand and id registers cleared.
  - grant is forced to 0 while reset==0.
- Arbitration (combinational, cycle G):
  - Scan requesters from ptr upward with wrap-around. grant[k]=1 for the first k with req[k]=1.
  - grant=0 if req==0.
  - At most one grant bit is high.
- Capture at the G edge (grant!=0):
  - op_a<=a[k], op_b<=b[k], id<=k, ptr<=(k+1) mod N_REQ.
  - If no grant: ptr holds and the stage-1 valid is cleared.
- Result, cycle G+1:
  - rsp_valid[id]=1, rsp_id=id, rsp_data=result(op_a,op_b). Fixed latency of 1 cycle from grant.
  - rsp_data and rsp_id hold their last values when rsp_valid==0.
- Arithmetic:
  - p = signed(op_a)*signed(op_b) at full 2*WIDTH width.
  - q = p >>> FRAC (arithmetic shift).
  - SATURATE=0: result = q[WIDTH-1:0].
  - SATURATE=1: result = q clamped to [-2^(WIDTH-1), 2^(WIDTH-1)-1].
- Handshake rules:
  - Requester holds req, a and b stable until it sees its grant bit.
  - From G+1 it may change operands or drop req.
  - A requester that keeps req high after its grant re-enters arbitration at G+1. Round-robin order means any other active requester wins first.
- Throughput: one grant per cycle. Worst-case wait for any holding requester is N_REQ-1 cycles (starvation-free).
- Reset mid-operation: an operation granted in the cycle before a reset edge is discarded. No rsp_valid is produced after that reset edge.
- Simultaneous grant and response in the same cycle is normal pipelined operation. A requester may receive rsp_valid for op n in the same cycle it is granted op n+1.

Decomposition:
- Shared package sim_pkg holds:
  - typedef fixed_t (signed 16-bit)
  - constant FRAC_BITS=4
  - constant N_PARTICLES
  - function sat_narrow (clamp from 2*WIDTH to WIDTH)
- Sub-module rr_arbiter (parameter N):
  - inputs: clk, reset, req, advance
  - outputs: one-hot grant, encoded grant index
  - owns ptr
- mult_arbiter instantiates rr_arbiter and contains the operand mux, capture registers, multiplier and narrowing stage.

Test Plan:
- Single request, FRAC=4, SATURATE=0: req=0001, a0=48, b0=-32 → grant=0001 in cycle G; in G+1 rsp_valid=0001, rsp_id=0, rsp_data=-96; no other rsp_valid.
- Full contention from reset: req=1111 held with distinct operands → grants 0001,0010,0100,1000,0001 on consecutive cycles; each response arrives exactly 1 cycle after its grant with the correct id.
- Narrowing, FRAC=0: a=32767, b=2 → SATURATE=1 gives rsp_data=32767; SATURATE=0 gives rsp_data=-2. a=-32768, b=2 with SATURATE=1 gives -32768.
- Fairness: req0 and req2 held high continuously → grants alternate 0,2,0,2; req1 raised later is granted within 2 cycles.
- Reset mid-operation: grant requester 3 in cycle G, drive reset=0 at the G edge → rsp_valid stays 0; after release, ptr=0 and req=1010 grants requester 1 first.
- Idle: req=0 for 10 cycles → grant=0, rsp_valid=0, busy=0, rsp_data unchanged from the last result.

Source files
------------

// File: rtl/sim_pkg.sv
// Shared fixed-point definitions for the particle simulation datapath.
package sim_pkg;

    localparam int FIXED_W     = 16;
    localparam int FRAC_BITS   = 4;
    localparam int N_PARTICLES = 4;

    typedef logic signed [FIXED_W-1:0] fixed_t;

    // Clamp a sign-extended wide value into the signed range of a w-bit word.
    // The caller keeps the low w bits of the returned value.
    function automatic logic signed [63:0] sat_narrow(input logic signed [63:0] q,
                                                      input int w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (q > hi) begin
            return hi;
        end else if (q < lo) begin
            return lo;
        end
        return q;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: scans from ptr upward with wrap, grants the first
// active requester, and moves ptr just past the winner when advance is high.
module rr_arbiter #(
    parameter  int N  = 4,
    localparam int IW = $clog2(N)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [N-1:0]  req,
    input  logic          advance,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx
);

    logic [IW-1:0] ptr;
    logic [IW-1:0] ptr_nxt;
    int            idx;
    logic          found;

    // Pick the first requester at or after ptr; nothing is granted in reset.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = 0;
        if (reset) begin
            for (int i = 0; i < N; i++) begin
                idx = int'(ptr) + i;
                if (idx >= N) begin
                    idx = idx - N;
                end
                if (!found && req[idx[IW-1:0]]) begin
                    grant[idx[IW-1:0]] = 1'b1;
                    grant_idx          = idx[IW-1:0];
                    found              = 1'b1;
                end
            end
        end
    end

    // Next pointer is the slot after the winner, wrapping at N (N need not be a power of two).
    always_comb begin
        ptr_nxt = (grant_idx == IW'(N - 1)) ? '0 : grant_idx + 1'b1;
    end

    // Pointer only moves when a grant is actually taken.
    always_ff @(posedge clk) begin
        if (!reset) begin
            ptr <= '0;
        end else if (advance) begin
            ptr <= ptr_nxt;
        end
    end

endmodule

// File: rtl/mult_arbiter.sv
// Shares one signed fixed-point multiplier between N_REQ requesters. The
// winning operands are captured at the grant edge and the narrowed product
// of the captured operands is presented, tagged, in the following cycle.
module mult_arbiter
    import sim_pkg::*;
#(
    parameter  int N_REQ    = N_PARTICLES,
    parameter  int WIDTH    = FIXED_W,
    parameter  int FRAC     = FRAC_BITS,
    parameter  int SATURATE = 0,
    localparam int IDW      = $clog2(N_REQ)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [N_REQ-1:0]          req,
    input  logic [N_REQ*WIDTH-1:0]    a,
    input  logic [N_REQ*WIDTH-1:0]    b,
    output logic [N_REQ-1:0]          grant,
    output logic [N_REQ-1:0]          rsp_valid,
    output logic signed [WIDTH-1:0]   rsp_data,
    output logic [IDW-1:0]            rsp_id,
    output logic                      busy
);

    logic [IDW-1:0]           grant_idx;
    logic                     grant_any;
    logic signed [WIDTH-1:0]  sel_a;
    logic signed [WIDTH-1:0]  sel_b;
    logic signed [WIDTH-1:0]  op_a;
    logic signed [WIDTH-1:0]  op_b;
    logic [IDW-1:0]           id;
    logic signed [2*WIDTH-1:0] prod;
    logic signed [2*WIDTH-1:0] q;

    assign grant_any = |grant;

    rr_arbiter #(.N(N_REQ)) u_arb (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .advance   (grant_any),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    // Operand mux for the current winner.
    always_comb begin
        sel_a = a[int'(grant_idx)*WIDTH +: WIDTH];
        sel_b = b[int'(grant_idx)*WIDTH +: WIDTH];
    end

    // Capture the winner's operands and tag; a reset edge discards an in-flight grant.
    always_ff @(posedge clk) begin
        if (!reset) begin
            op_a      <= '0;
            op_b      <= '0;
            id        <= '0;
            rsp_valid <= '0;
            busy      <= 1'b0;
        end else begin
            rsp_valid <= grant;
            busy      <= grant_any;
            if (grant_any) begin
                op_a <= sel_a;
                op_b <= sel_b;
                id   <= grant_idx;
            end
        end
    end

    // Product of the held operands: driven only by flops, and it holds its
    // value between grants because the operands only change on a grant.
    always_comb begin
        prod   = (2*WIDTH)'(op_a) * (2*WIDTH)'(op_b);
        q      = prod >>> FRAC;
        rsp_data = (SATURATE != 0) ? WIDTH'(sat_narrow(64'(q), WIDTH))
                                   : q[WIDTH-1:0];
        rsp_id = id;
    end

endmodule

// File: tb/tb_mult_arbiter.sv
// Scoreboard bench for mult_arbiter: three instances share one stimulus
// stream (FRAC=4 truncate, FRAC=0 saturate, FRAC=0 truncate).
module tb_mult_arbiter;

    localparam int N = 4;
    localparam int W = 16;

    typedef struct {
        int                   id;
        int                   due;
        logic [2:0][W-1:0]    data;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic [N-1:0] req = '0;
    logic signed [W-1:0] av [N];
    logic signed [W-1:0] bv [N];
    logic [N*W-1:0] a_bus;
    logic [N*W-1:0] b_bus;

    logic [N-1:0] gt [3];
    logic [N-1:0] rv [3];
    logic [W-1:0] rd [3];
    logic [1:0]   ri [3];
    logic         bs [3];

    exp_t         sb [$];
    logic [W-1:0] last_data [3];
    int           cyc = 0;
    int           n_checks = 0;
    int           n_fail = 0;
    logic         prev_g = 1'b0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always_comb begin
        a_bus = '0;
        b_bus = '0;
        for (int i = 0; i < N; i++) begin
            a_bus[i*W +: W] = av[i];
            b_bus[i*W +: W] = bv[i];
        end
    end

    mult_arbiter #(.N_REQ(N), .WIDTH(W), .FRAC(4), .SATURATE(0)) u_dut0 (
        .clk(clk), .reset(reset), .req(req), .a(a_bus), .b(b_bus),
        .grant(gt[0]), .rsp_valid(rv[0]), .rsp_data(rd[0]), .rsp_id(ri[0]), .busy(bs[0]));

    mult_arbiter #(.N_REQ(N), .WIDTH(W), .FRAC(0), .SATURATE(1)) u_dut1 (
        .clk(clk), .reset(reset), .req(req), .a(a_bus), .b(b_bus),
        .grant(gt[1]), .rsp_valid(rv[1]), .rsp_data(rd[1]), .rsp_id(ri[1]), .busy(bs[1]));

    mult_arbiter #(.N_REQ(N), .WIDTH(W), .FRAC(0), .SATURATE(0)) u_dut2 (
        .clk(clk), .reset(reset), .req(req), .a(a_bus), .b(b_bus),
        .grant(gt[2]), .rsp_valid(rv[2]), .rsp_data(rd[2]), .rsp_id(ri[2]), .busy(bs[2]));

    // Reference arithmetic for configuration d, done in 64-bit integers.
    function automatic logic [W-1:0] model(input logic signed [W-1:0] x,
                                           input logic signed [W-1:0] y,
                                           input int d);
        longint p;
        int     frac;
        frac = (d == 0) ? 4 : 0;
        p = longint'(x) * longint'(y);
        p = p >>> frac;
        if (d == 1) begin
            if (p > 32767) p = 32767;
            else if (p < -32768) p = -32768;
        end
        return p[W-1:0];
    endfunction

    task automatic chk(input string name, input int d,
                       input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cfg%0d cycle %0d: got %0h expected %0h", name, d, cyc, act, exp);
        end
    endtask

    // Monitor: a due entry must be answered now with the right tag and data;
    // otherwise no response may appear.
    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0 && sb[0].due == cyc) begin
            e = sb.pop_front();
            for (int d = 0; d < 3; d++) begin
                chk("rsp_valid", d, 32'(rv[d]), 32'(4'b0001 << e.id));
                chk("rsp_id", d, 32'(ri[d]), 32'(e.id));
                chk("rsp_data", d, 32'(rd[d]), 32'(e.data[d]));
                last_data[d] = e.data[d];
            end
        end else begin
            for (int d = 0; d < 3; d++) begin
                chk("no_rsp", d, 32'(rv[d]), 32'd0);
            end
        end
    end

    task automatic step(input logic [N-1:0] r, input logic [N-1:0] eg, input bit push);
        exp_t e;
        @(negedge clk);
        for (int d = 0; d < 3; d++) chk("busy", d, 32'(bs[d]), 32'(prev_g));
        req = r;
        #1;
        for (int d = 0; d < 3; d++) chk("grant", d, 32'(gt[d]), 32'(eg));
        if (eg != 0 && push) begin
            e.id = 0;
            for (int i = 0; i < N; i++) if (eg[i]) e.id = i;
            e.due = cyc + 1;
            for (int d = 0; d < 3; d++) e.data[d] = model(av[e.id], bv[e.id], d);
            sb.push_back(e);
        end
        prev_g = (eg != 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        req = '0;
        @(negedge clk);
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            chk("rst_valid", d, 32'(rv[d]), 32'd0);
            chk("rst_data", d, 32'(rd[d]), 32'd0);
            chk("rst_id", d, 32'(ri[d]), 32'd0);
            chk("rst_busy", d, 32'(bs[d]), 32'd0);
        end
        reset = 1'b1;
        prev_g = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < N; i++) begin
            av[i] = '0;
            bv[i] = '0;
        end
        for (int d = 0; d < 3; d++) last_data[d] = '0;
        do_reset();

        // single request: 48 * -32 >>> 4 = -96
        av[0] = 48; bv[0] = -32;
        step(4'b0001, 4'b0001, 1);
        step(4'b0000, 4'b0000, 1);

        // full contention from reset, including the narrowing boundaries
        do_reset();
        av[0] = 48;     bv[0] = -32;
        av[1] = -5;     bv[1] = 7;
        av[2] = 32767;  bv[2] = 2;
        av[3] = -32768; bv[3] = 2;
        step(4'b1111, 4'b0001, 1);
        step(4'b1111, 4'b0010, 1);
        step(4'b1111, 4'b0100, 1);
        step(4'b1111, 4'b1000, 1);
        step(4'b1111, 4'b0001, 1);

        // fairness: req0 and req2 alternate, req1 joins later (ptr starts at 1)
        av[2] = 1000; bv[2] = -1000;
        av[1] = 300;  bv[1] = -3;
        step(4'b0101, 4'b0100, 1);
        step(4'b0101, 4'b0001, 1);
        step(4'b0101, 4'b0100, 1);
        step(4'b0101, 4'b0001, 1);
        step(4'b0101, 4'b0100, 1);
        step(4'b0111, 4'b0001, 1);
        step(4'b0111, 4'b0010, 1);
        step(4'b0111, 4'b0100, 1);
        step(4'b0111, 4'b0001, 1);

        // idle: nothing granted, outputs hold the last result
        for (int i = 0; i < 10; i++) begin
            step(4'b0000, 4'b0000, 1);
            for (int d = 0; d < 3; d++) chk("hold_data", d, 32'(rd[d]), 32'(last_data[d]));
        end

        // reset mid-operation: requester 3 granted, reset taken at that edge
        av[3] = -7; bv[3] = 9;
        step(4'b1000, 4'b1000, 0);
        reset = 1'b0;
        #1;
        for (int d = 0; d < 3; d++) chk("grant_in_reset", d, 32'(gt[d]), 32'd0);
        @(negedge clk);
        for (int d = 0; d < 3; d++) chk("discarded", d, 32'(rv[d]), 32'd0);
        req = '0;
        reset = 1'b1;
        prev_g = 1'b0;
        av[1] = -300; bv[1] = 40;
        step(4'b1010, 4'b0010, 1);
        step(4'b0000, 4'b0000, 1);
        step(4'b0000, 4'b0000, 1);

        chk("sb_empty", 0, 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
